// File: rtl/writeback_v_pkg.sv
// rtl/writeback_v_pkg.sv - shared encodings for the writeback stage
package writeback_v_pkg;
   localparam logic [1:0] WB_ALU = 2'd0;
   localparam logic [1:0] WB_MEM = 2'd1;
   localparam logic [1:0] WB_PC4 = 2'd2;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   typedef enum logic [1:0] {IDLE, WAIT_MEM, COMMIT} state_t;
endpackage

// File: rtl/writeback_v_align.sv
// rtl/writeback_v_align.sv - load data alignment, extension and error detection
module load_align_v
   import writeback_v_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] mem_rdata,
   input  logic [1:0]      offset,
   input  logic [2:0]      funct3,
   output logic [XLEN-1:0] data,
   output logic            err
);
   logic [7:0]  byte_v;
   logic [15:0] half_v;

   assign byte_v = mem_rdata[8*offset +: 8];
   assign half_v = offset[1] ? mem_rdata[31:16] : mem_rdata[15:0];

   always_comb begin
      data = '0;
      err  = 1'b0;
      case (funct3)
         F3_LB:  data = {{(XLEN-8){byte_v[7]}}, byte_v};
         F3_LBU: data = {{(XLEN-8){1'b0}}, byte_v};
         F3_LH: begin
            data = {{(XLEN-16){half_v[15]}}, half_v};
            err  = offset[0];
         end
         F3_LHU: begin
            data = {{(XLEN-16){1'b0}}, half_v};
            err  = offset[0];
         end
         F3_LW: begin
            data = mem_rdata;
            err  = (offset != 2'd0);
         end
         default: err = 1'b1;
      endcase
   end
endmodule

// File: rtl/writeback_v.sv
// rtl/writeback_v.sv - writeback stage: register-file writer and retire counter
module writeback_v
   import writeback_v_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int CNT_W = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [4:0]       in_rd,
   input  logic             in_regWrite,
   input  logic [1:0]       in_wbSel,
   input  logic [2:0]       in_funct3,
   input  logic [XLEN-1:0]  in_aluResult,
   input  logic [XLEN-1:0]  in_pc4,
   input  logic             mem_rvalid,
   input  logic [XLEN-1:0]  mem_rdata,
   output logic             isWrite,
   output logic [4:0]       rd,
   output logic [XLEN-1:0]  writeData,
   output logic             load_err,
   output logic [CNT_W-1:0] instret
);
   state_t          state, next_state;
   logic            accept, accept_load, load_done;
   logic [4:0]      rd_q;
   logic            reg_write_q;
   logic [2:0]      funct3_q;
   logic [1:0]      offset_q;
   logic [XLEN-1:0] aligned, direct_data;
   logic            align_err;

   load_align_v #(.XLEN(XLEN)) u_align (
      .mem_rdata (mem_rdata),
      .offset    (offset_q),
      .funct3    (funct3_q),
      .data      (aligned),
      .err       (align_err)
   );

   assign in_ready    = (state != WAIT_MEM);
   assign accept      = in_valid & in_ready;
   assign accept_load = accept & (in_wbSel == WB_MEM);
   assign load_done   = (state == WAIT_MEM) & mem_rvalid;
   assign direct_data = (in_wbSel == WB_PC4) ? in_pc4 : in_aluResult;

   always_comb begin
      next_state = state;
      case (state)
         IDLE, COMMIT: begin
            if (accept_load)  next_state = WAIT_MEM;
            else if (accept)  next_state = COMMIT;
            else              next_state = IDLE;
         end
         WAIT_MEM: if (mem_rvalid) next_state = COMMIT;
         default:  next_state = IDLE;
      endcase
   end

   // Outputs are registered on entry to COMMIT, so they hold for exactly that one cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         isWrite     <= 1'b0;
         rd          <= '0;
         writeData   <= '0;
         load_err    <= 1'b0;
         instret     <= '0;
         rd_q        <= '0;
         reg_write_q <= 1'b0;
         funct3_q    <= '0;
         offset_q    <= '0;
      end else begin
         state    <= next_state;
         isWrite  <= 1'b0;
         load_err <= 1'b0;
         if (state == COMMIT)
            instret <= instret + {{(CNT_W-1){1'b0}}, 1'b1};
         if (accept) begin
            rd_q        <= in_rd;
            reg_write_q <= in_regWrite;
            funct3_q    <= in_funct3;
            offset_q    <= in_aluResult[1:0];
            if (!accept_load) begin
               rd        <= in_rd;
               writeData <= direct_data;
               isWrite   <= in_regWrite & (in_rd != 5'd0);
            end
         end
         if (load_done) begin
            rd        <= rd_q;
            writeData <= aligned;
            isWrite   <= reg_write_q & (rd_q != 5'd0) & ~align_err;
            load_err  <= align_err;
         end
      end
   end
endmodule

// File: tb/tb_writeback_v.sv
// tb/tb_writeback_v.sv - self-checking bench for writeback_v
module tb_writeback_v;
   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  in_rd;
   logic        in_regWrite;
   logic [1:0]  in_wbSel;
   logic [2:0]  in_funct3;
   logic [31:0] in_aluResult;
   logic [31:0] in_pc4;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
   logic        isWrite;
   logic [4:0]  rd;
   logic [31:0] writeData;
   logic        load_err;
   logic [63:0] instret;

   int errors = 0;
   int checks = 0;
   bit chk_en = 0;

   writeback_v #(.XLEN(32), .CNT_W(64)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_rd(in_rd), .in_regWrite(in_regWrite), .in_wbSel(in_wbSel),
      .in_funct3(in_funct3), .in_aluResult(in_aluResult), .in_pc4(in_pc4),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .isWrite(isWrite),
      .rd(rd), .writeData(writeData), .load_err(load_err), .instret(instret)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference load result: {err, data}
   function automatic logic [32:0] model_load(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] w);
      logic [31:0] v;
      case (f3)
         3'b000, 3'b100: begin
            v = (w >> (8 * off)) & 32'hFF;
            if (f3 == 3'b000 && v >= 32'd128) v = v | 32'hFFFF_FF00;
            return {1'b0, v};
         end
         3'b001, 3'b101: begin
            v = (w >> (16 * off[1])) & 32'hFFFF;
            if (f3 == 3'b001 && v >= 32'd32768) v = v | 32'hFFFF_0000;
            return {off[0], v};
         end
         3'b010:  return {off != 2'd0, w};
         default: return {1'b1, 32'h0};
      endcase
   endfunction

   // Transaction-level model: one pending load, and the commit expected in the current cycle.
   bit          m_pending, m_p_rw, m_commit, m_we, m_err;
   logic [4:0]  m_p_rd, m_rd;
   logic [2:0]  m_p_f3;
   logic [1:0]  m_p_off;
   logic [31:0] m_data;
   logic [63:0] m_instret;

   always @(posedge clk) begin
      logic [32:0] r;
      bit nc, rw, er;
      if (reset) begin
         m_pending = 0; m_commit = 0; m_we = 0; m_err = 0; m_instret = 0;
      end else begin
         nc = 0; rw = 0; er = 0;
         if (m_commit) m_instret = m_instret + 1;
         if (m_pending) begin
            if (mem_rvalid) begin
               r = model_load(m_p_f3, m_p_off, mem_rdata);
               nc = 1; rw = m_p_rw; er = r[32]; m_rd = m_p_rd; m_data = r[31:0];
               m_pending = 0;
            end
         end else if (in_valid) begin
            if (in_wbSel == 2'd1) begin
               m_pending = 1; m_p_rd = in_rd; m_p_rw = in_regWrite;
               m_p_f3 = in_funct3; m_p_off = in_aluResult[1:0];
            end else begin
               nc = 1; rw = in_regWrite; m_rd = in_rd;
               m_data = (in_wbSel == 2'd2) ? in_pc4 : in_aluResult;
            end
         end
         m_commit = nc;
         m_err = nc & er;
         m_we = nc & rw & (m_rd != 5'd0) & ~er;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("cmp_in_ready", in_ready, !m_pending);
         check("cmp_isWrite", isWrite, m_we);
         check("cmp_load_err", load_err, m_err);
         check("cmp_instret", instret, m_instret);
         if (m_we) begin
            check("cmp_rd", rd, m_rd);
            check("cmp_writeData", writeData, m_data);
         end
      end
   end

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic issue(input logic [4:0] r, input logic rw, input logic [1:0] sel,
                        input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] pc4);
      in_valid = 1; in_rd = r; in_regWrite = rw; in_wbSel = sel;
      in_funct3 = f3; in_aluResult = alu; in_pc4 = pc4;
   endtask

   initial begin
      logic [63:0] base;
      reset = 1; in_valid = 0; in_rd = 0; in_regWrite = 0; in_wbSel = 0; in_funct3 = 0;
      in_aluResult = 0; in_pc4 = 0; mem_rvalid = 0; mem_rdata = 0;
      step(); step();
      chk_en = 1;
      reset = 0;
      check("reset_isWrite", isWrite, 0);
      check("reset_rd", rd, 0);
      check("reset_writeData", writeData, 0);
      check("reset_instret", instret, 0);
      check("reset_in_ready", in_ready, 1);

      // ALU writeback
      issue(5, 1, 0, 0, 32'h0000_1234, 0);
      step(); in_valid = 0;
      check("alu_isWrite", isWrite, 1);
      check("alu_rd", rd, 5);
      check("alu_data", writeData, 32'h0000_1234);
      check("alu_instret_before", instret, 0);
      step();
      check("alu_instret_after", instret, 1);
      check("alu_isWrite_drop", isWrite, 0);

      // LB with three wait cycles
      issue(3, 1, 1, 3'b000, 32'h0000_1002, 0);
      step(); in_valid = 0;
      for (int i = 0; i < 3; i++) begin
         check("lb_wait_ready", in_ready, 0);
         step();
      end
      mem_rvalid = 1; mem_rdata = 32'h0080_0000;
      step(); mem_rvalid = 0;
      check("lb_isWrite", isWrite, 1);
      check("lb_data", writeData, 32'hFFFF_FF80);
      step();

      // LHU at offset 2
      issue(9, 1, 1, 3'b101, 32'h0000_2002, 0);
      step(); in_valid = 0;
      mem_rvalid = 1; mem_rdata = 32'hBEEF_0000;
      step(); mem_rvalid = 0;
      check("lhu_data", writeData, 32'h0000_BEEF);
      step();

      // Misaligned LW
      base = instret;
      issue(4, 1, 1, 3'b010, 32'h0000_3001, 0);
      step(); in_valid = 0;
      mem_rvalid = 1; mem_rdata = 32'h1234_5678;
      step(); mem_rvalid = 0;
      check("lw_mis_err", load_err, 1);
      check("lw_mis_isWrite", isWrite, 0);
      step();
      check("lw_mis_err_pulse", load_err, 0);
      check("lw_mis_instret", instret, base + 1);

      // x0 write followed back-to-back by PC+4 write
      base = instret;
      issue(0, 1, 0, 0, 32'hDEAD_BEEF, 0);
      step();
      issue(7, 1, 2, 0, 32'h5555_5555, 32'h0000_0104);
      check("x0_isWrite", isWrite, 0);
      check("b2b_ready", in_ready, 1);
      step(); in_valid = 0;
      check("pc4_isWrite", isWrite, 1);
      check("pc4_rd", rd, 7);
      check("pc4_data", writeData, 32'h0000_0104);
      step();
      check("b2b_instret", instret, base + 2);

      // Reset during WAIT_MEM, then a stray mem_rvalid
      issue(6, 1, 1, 3'b010, 32'h0000_4000, 0);
      step(); in_valid = 0;
      reset = 1;
      step(); reset = 0;
      mem_rvalid = 1; mem_rdata = 32'hCAFE_F00D;
      step(); mem_rvalid = 0;
      check("rst_wait_isWrite", isWrite, 0);
      check("rst_wait_instret", instret, 0);
      check("rst_wait_ready", in_ready, 1);
      step();

      // Randomized traffic checked by the model
      for (int c = 0; c < 3000; c++) begin
         reset = ($urandom_range(0, 299) == 0);
         in_valid = ($urandom_range(0, 9) < 7);
         in_rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
         in_regWrite = ($urandom_range(0, 9) < 8);
         in_wbSel = 2'($urandom);
         in_funct3 = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'(($urandom_range(0, 4) > 2) ? 3'b100 + 3'($urandom_range(0, 1)) : 3'($urandom_range(0, 2)));
         in_aluResult = $urandom;
         in_pc4 = $urandom;
         mem_rvalid = ($urandom_range(0, 9) < 3);
         mem_rdata = $urandom;
         step();
      end
      reset = 0; in_valid = 0; mem_rvalid = 0;
      step(); step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/writeback_v.md
Name: writeback_v

Overview:
- Writeback stage: the writer side of the 32x32 register file. Drives its write port (isWrite, rd, writeData).
- Accepts retiring instructions from the MEM stage over a valid/ready handshake.
- Waits for load data from data memory, then aligns and sign/zero-extends it.
- Issues exactly one register write per retired instruction and counts retired instructions.

Parameters:
- XLEN, 32, data width.
- CNT_W, 64, width of retired-instruction counter.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  MEM stage presents an instruction.
- in_ready  out  1  stage can accept this cycle.
- in_rd  in  5  destination register.
- in_regWrite  in  1  instruction writes rd.
- in_wbSel  in  2  writeback source: 0=ALU, 1=MEM load, 2=PC+4, 3=reserved (treated as ALU).
- in_funct3  in  3  load width/sign code.
- in_aluResult  in  XLEN  ALU result; load byte address for loads.
- in_pc4  in  XLEN  PC+4, for JAL/JALR.
- mem_rvalid  in  1  load data valid.
- mem_rdata  in  XLEN  word-aligned load data.
- isWrite  out  1  register file write enable.
- rd  out  5  register file write index.
- writeData  out  XLEN  register file write data.
- load_err  out  1  one-cycle pulse: misaligned or illegal load.
- instret  out  CNT_W  retired-instruction count.

Behaviour:
- Reset (synchronous, active-high): state=IDLE; isWrite=0; rd=0; writeData=0; load_err=0; instret=0; all captured fields cleared. Reset mid-WAIT_MEM abandons the load; any later mem_rvalid is ignored.
- States: IDLE, WAIT_MEM, COMMIT.
- in_ready=1 in IDLE and COMMIT, 0 in WAIT_MEM. Accept = in_valid & in_ready.
- On accept with wbSel!=1: capture fields, select data (0/3 -> aluResult, 2 -> pc4), go to COMMIT. Latency: write visible one cycle after accept.
- On accept with wbSel=1: capture fields and offset=aluResult[1:0], go to WAIT_MEM.
- WAIT_MEM: stay until mem_rvalid=1. Then align mem_rdata, go to COMMIT. mem_rvalid in any other state is ignored.
- Load alignment:
  - LB 000: sign-extend byte at offset.
  - LBU 100: zero-extend byte at offset.
  - LH 001: sign-extend halfword at offset[1].
  - LHU 101: zero-extend halfword at offset[1].
  - LW 010: full word.
- Load errors (misaligned or illegal):
  - LH/LHU with offset[0]=1 is misaligned.
  - LW with offset!=0 is misaligned.
  - funct3 in {011,110,111} is illegal.
  - On error: no register write, load_err=1 during the COMMIT cycle, instruction still counted in instret.
- COMMIT (exactly one cycle per instruction):
  - isWrite = regWrite & (rd!=0) & ~err. rd and writeData hold captured values.
  - instret increments by 1, wrapping at 2^CNT_W.
  - Next state: if a new instruction is accepted, COMMIT (non-load) or WAIT_MEM (load); else IDLE. Back-to-back throughput is 1 per cycle for non-loads.
- Outside COMMIT: isWrite=0 and load_err=0. rd and writeData hold their last values.
- Writes to x0 are never issued: isWrite=0 even if regWrite=1. The instruction is still counted.
- Register file write occurs at the clock edge ending COMMIT. The read-after-write bypass is the decode stage's concern, not this block's.

Decomposition:
- Shared package/include holds:
  - wbSel encodings WB_ALU=0, WB_MEM=1, WB_PC4=2.
  - funct3 load codes F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU.
  - State encodings IDLE, WAIT_MEM, COMMIT.
- One natural sub-module: load_align_v, combinational. Inputs mem_rdata, offset, funct3. Outputs aligned data and err.

Test Plan:
- ALU writeback: accept rd=5, regWrite=1, wbSel=0, aluResult=0x0000_1234 -> next cycle isWrite=1, rd=5, writeData=0x0000_1234, instret 0->1.
- LB sign extension: wbSel=1, funct3=000, addr=0x...2, mem_rdata=0x0080_0000 after 3 wait cycles -> in_ready=0 for those 3 cycles, then isWrite=1, writeData=0xFFFF_FF80.
- LHU: funct3=101, offset=2, mem_rdata=0xBEEF_0000 -> writeData=0x0000_BEEF.
- Misaligned LW: offset=1 -> load_err pulses 1 cycle, isWrite=0, instret increments.
- x0 and back-to-back: rd=0 regWrite=1 followed next cycle by rd=7 wbSel=2 pc4=0x104 -> first commit isWrite=0, second isWrite=1, writeData=0x104, instret +2 over 2 consecutive cycles.
- Reset in WAIT_MEM, then stray mem_rvalid -> state IDLE, no write, instret=0.
